// File: rtl/channel_frame_fifo_if.sv
// Bus bundle between the channel framer/mixer side and channel_frame_fifo.
// The slave modport is the FIFO view; the master modport is the environment view.
interface channel_frame_fifo_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] DIN;
   logic                  WE;
   logic [DATA_WIDTH-1:0] DOUT;
   logic                  RE;
   logic                  READ_REQUEST;
   logic [ADDR_WIDTH-1:0] FRAME_COUNT;
   logic [15:0]           DROP_COUNT;
   logic                  UNDERFLOW;

   modport slave (
      input  DIN, WE, RE,
      output DOUT, READ_REQUEST, FRAME_COUNT, DROP_COUNT, UNDERFLOW
   );

   modport master (
      output DIN, WE, RE,
      input  DOUT, READ_REQUEST, FRAME_COUNT, DROP_COUNT, UNDERFLOW
   );
endinterface

// File: rtl/channel_frame_fifo.sv
// channel_frame_fifo: per-channel frame buffer feeding the two-channel mixer.
// Words are written speculatively at wr_spec and become visible to the reader
// only once the frame footer moves wr_commit. Broken, overflowing or timed-out
// frames are rewound to wr_commit and counted in DROP_COUNT.
// Optional feature macro: FRAME_TIMEOUT_EN (idle-cycle timeout inside a frame).
module channel_frame_fifo #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 9,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                 CLK,
   input logic                 RESETN,
   channel_frame_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};

   // A header discarded while full shares the dropping behaviour, so one
   // state covers both dropping flavours.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_FRAME = 2'd1,
      ST_DROPPING = 2'd2
   } state_t;

   function automatic logic is_header(input logic [DATA_WIDTH-1:0] w);
      return (w[63:48] == 16'hAAAA);
   endfunction

   // Header takes priority over footer when a word matches both.
   function automatic logic is_footer(input logic [DATA_WIDTH-1:0] w);
      return (w[15:0] == 16'h5555) && (w[63:62] == 2'b11) && !is_header(w);
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_commit_q, wr_commit_d;
   logic [ADDR_WIDTH-1:0] wr_spec_q, wr_spec_d;
   logic [ADDR_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [15:0]           drop_count_q, drop_count_d;
   logic                  read_request_q, read_request_d;
   logic                  underflow_q, underflow_d;

   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_waddr_s;
   logic                  commit_s;
   logic                  drop_s;
   logic                  hdr_s;
   logic                  ftr_s;
   logic                  full_s;
   logic                  readable_s;
   logic                  consume_s;
   logic                  ftr_consume_s;

`ifdef FRAME_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic        timeout_s;

   // Idle counter: runs only on WE-free cycles inside a frame.
   always_comb begin
      idle_cnt_d = 16'd0;
      timeout_s  = 1'b0;
      if ((state_q == ST_IN_FRAME) && !bus.WE) begin
         if (idle_cnt_q == TIMEOUT_LAST) begin
            timeout_s = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
         end
      end else begin
         idle_cnt_d = 16'd0;
      end
   end

   // Idle counter register.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         idle_cnt_q <= 16'd0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

   // Write FSM: frame parsing, speculative writes, commit and rewind.
   always_comb begin
      state_d     = state_q;
      wr_spec_d   = wr_spec_q;
      wr_commit_d = wr_commit_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = wr_spec_q;
      commit_s    = 1'b0;
      drop_s      = 1'b0;
      hdr_s       = is_header(bus.DIN);
      ftr_s       = is_footer(bus.DIN);
      // Fullness uses the pre-edge read pointer.
      full_s      = ((wr_spec_q + PTR_ONE) == rd_ptr_q);
      case (state_q)
         ST_IDLE, ST_DROPPING: begin
            if (bus.WE && hdr_s) begin
               if (!full_s) begin
                  mem_we_s  = 1'b1;
                  wr_spec_d = wr_spec_q + PTR_ONE;
                  state_d   = ST_IN_FRAME;
               end else begin
                  drop_s  = 1'b1;
                  state_d = ST_DROPPING;
               end
            end else if (bus.WE && ftr_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_IN_FRAME: begin
            if (bus.WE) begin
               if (full_s) begin
                  wr_spec_d = wr_commit_q;
                  drop_s    = 1'b1;
                  state_d   = ST_DROPPING;
               end else if (hdr_s) begin
                  // Lost footer: restart the frame at the commit point.
                  drop_s      = 1'b1;
                  mem_we_s    = 1'b1;
                  mem_waddr_s = wr_commit_q;
                  wr_spec_d   = wr_commit_q + PTR_ONE;
               end else if (ftr_s) begin
                  mem_we_s    = 1'b1;
                  wr_spec_d   = wr_spec_q + PTR_ONE;
                  wr_commit_d = wr_spec_q + PTR_ONE;
                  commit_s    = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  mem_we_s  = 1'b1;
                  wr_spec_d = wr_spec_q + PTR_ONE;
               end
            end else begin
`ifdef FRAME_TIMEOUT_EN
               if (timeout_s) begin
                  wr_spec_d = wr_commit_q;
                  drop_s    = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_IN_FRAME;
               end
`else
               state_d = ST_IN_FRAME;
`endif
            end
         end
         default: begin
            state_d   = ST_IDLE;
            wr_spec_d = wr_commit_q;
         end
      endcase
   end

   // Read side, frame accounting and status flags.
   always_comb begin
      readable_s    = (rd_ptr_q != wr_commit_q);
      consume_s     = bus.RE && readable_s;
      ftr_consume_s = consume_s && is_footer(mem_q[rd_ptr_q]);
      if (consume_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      underflow_d = underflow_q | (bus.RE & ~readable_s);
      case ({commit_s, ftr_consume_s})
         2'b10:   frame_count_d = frame_count_q + PTR_ONE;
         2'b01:   frame_count_d = frame_count_q - PTR_ONE;
         default: frame_count_d = frame_count_q;
      endcase
      if (drop_s && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end else begin
         drop_count_d = drop_count_q;
      end
      read_request_d = (frame_count_d != PTR_ZERO);
   end

   // State, pointer and counter registers.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q        <= ST_IDLE;
         rd_ptr_q       <= PTR_ZERO;
         wr_commit_q    <= PTR_ZERO;
         wr_spec_q      <= PTR_ZERO;
         frame_count_q  <= PTR_ZERO;
         drop_count_q   <= 16'd0;
         read_request_q <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_commit_q    <= wr_commit_d;
         wr_spec_q      <= wr_spec_d;
         frame_count_q  <= frame_count_d;
         drop_count_q   <= drop_count_d;
         read_request_q <= read_request_d;
         underflow_q    <= underflow_d;
      end
   end

   // Frame RAM write port; contents are not reset.
   always_ff @(posedge CLK) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= bus.DIN;
      end
   end

   assign bus.DOUT         = mem_q[rd_ptr_q];
   assign bus.READ_REQUEST = read_request_q;
   assign bus.FRAME_COUNT  = frame_count_q;
   assign bus.DROP_COUNT   = drop_count_q;
   assign bus.UNDERFLOW    = underflow_q;
endmodule

// File: tb/tb_channel_frame_fifo.sv
// Testbench for channel_frame_fifo (ADDR_WIDTH=4, TIMEOUT_CYCLES=8).
// A queue-based frame model predicts every output each cycle; directed
// literal checks pin the model at the interesting points.
module tb_channel_frame_fifo;
   localparam int AW    = 4;
   localparam int DEPTH = 2 ** AW;
   localparam int TMO   = 8;

   logic CLK;
   logic RESETN;

   channel_frame_fifo_if #(.DATA_WIDTH(64), .ADDR_WIDTH(AW)) bus ();

   channel_frame_fifo #(
      .DATA_WIDTH(64), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .bus(bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Model state: committed words, the frame being assembled, parser mode.
   logic [63:0] qc[$];
   logic [63:0] qp[$];
   int          mode   = 0;   // 0 idle, 1 in frame, 2 dropping
   int          m_drop = 0;
   bit          m_uf   = 1'b0;
   int          m_idle = 0;
   bit          m_live = 1'b0;

   function automatic bit w_hdr(input logic [63:0] w);
      return w[63:48] == 16'hAAAA;
   endfunction
   function automatic bit w_ftr(input logic [63:0] w);
      return !w_hdr(w) && (w[15:0] == 16'h5555) && (w[63:62] == 2'b11);
   endfunction
   function automatic int model_fc();
      int n = 0;
      foreach (qc[i]) if (w_ftr(qc[i])) n++;
      return n;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bump();
      if (m_drop < 65535) m_drop++;
   endtask

   task automatic model_step(input logic rn, input logic we, input logic [63:0] d, input logic re);
      bit full, rdbl;
      if (!rn) begin
         qc.delete(); qp.delete();
         mode = 0; m_drop = 0; m_uf = 1'b0; m_idle = 0; m_live = 1'b1;
         return;
      end
      full = (qc.size() + qp.size()) == DEPTH - 1;
      rdbl = qc.size() != 0;
      if (re) begin
         if (rdbl) void'(qc.pop_front());
         else m_uf = 1'b1;
      end
      if (we) begin
         m_idle = 0;
         if (mode == 1) begin
            if (full) begin qp.delete(); bump(); mode = 2; end
            else if (w_hdr(d)) begin qp.delete(); bump(); qp.push_back(d); end
            else if (w_ftr(d)) begin
               qp.push_back(d);
               foreach (qp[i]) qc.push_back(qp[i]);
               qp.delete(); mode = 0;
            end
            else qp.push_back(d);
         end else begin
            if (w_hdr(d)) begin
               if (!full) begin qp.push_back(d); mode = 1; end
               else begin bump(); mode = 2; end
            end else if (w_ftr(d)) mode = 0;
         end
      end else if (mode == 1) begin
         m_idle++;
`ifdef FRAME_TIMEOUT_EN
         if (m_idle == TMO) begin qp.delete(); bump(); mode = 0; m_idle = 0; end
`endif
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model.
   task automatic cyc(input logic rn, input logic we, input logic [63:0] d, input logic re);
      RESETN = rn; bus.WE = we; bus.DIN = d; bus.RE = re;
      @(posedge CLK);
      model_step(rn, we, d, re);
      #2;
   endtask

   task automatic wr(input logic [63:0] d);
      cyc(1'b1, 1'b1, d, 1'b0);
   endtask
   task automatic rd();
      cyc(1'b1, 1'b0, 64'd0, 1'b1);
   endtask
   task automatic idle();
      cyc(1'b1, 1'b0, 64'd0, 1'b0);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (m_live) begin
         chk("FRAME_COUNT", 64'(bus.FRAME_COUNT), 64'(model_fc()));
         chk("DROP_COUNT", 64'(bus.DROP_COUNT), 64'(m_drop));
         chk("READ_REQUEST", 64'(bus.READ_REQUEST), 64'(model_fc() != 0));
         chk("UNDERFLOW", 64'(bus.UNDERFLOW), 64'(m_uf));
         if (qc.size() != 0) chk("DOUT", bus.DOUT, qc[0]);
      end
   end

   localparam logic [63:0] FTR = 64'hC000_0000_0000_5555;

   initial begin
      RESETN = 1'b0; bus.WE = 1'b0; bus.DIN = 64'd0; bus.RE = 1'b0;
      cyc(1'b0, 1'b0, 64'd0, 1'b0);
      cyc(1'b0, 1'b0, 64'd0, 1'b0);
      chk("rst_fc", 64'(bus.FRAME_COUNT), 64'd0);
      chk("rst_drop", 64'(bus.DROP_COUNT), 64'd0);
      chk("rst_rr", 64'(bus.READ_REQUEST), 64'd0);
      chk("rst_uf", 64'(bus.UNDERFLOW), 64'd0);

      // 1: single 3-word frame, then read it out
      wr(64'hAAAA_0000_0000_0001);
      wr(64'h0000_0000_0000_0002);
      chk("t1_rr_before_ftr", 64'(bus.READ_REQUEST), 64'd0);
      wr(FTR);
      chk("t1_rr", 64'(bus.READ_REQUEST), 64'd1);
      chk("t1_fc", 64'(bus.FRAME_COUNT), 64'd1);
      chk("t1_dout0", bus.DOUT, 64'hAAAA_0000_0000_0001);
      rd();
      chk("t1_dout1", bus.DOUT, 64'h0000_0000_0000_0002);
      rd();
      chk("t1_dout2", bus.DOUT, FTR);
      rd();
      chk("t1_fc_end", 64'(bus.FRAME_COUNT), 64'd0);
      chk("t1_rr_end", 64'(bus.READ_REQUEST), 64'd0);

      // 2: lost footer, restarted frame
      wr(64'hAAAA_0000_0000_0010);
      wr(64'h0000_0000_0000_0011);
      wr(64'h0000_0000_0000_0012);
      wr(64'hAAAA_0000_0000_0020);
      wr(64'h0000_0000_0000_0021);
      wr(FTR);
      chk("t2_drop", 64'(bus.DROP_COUNT), 64'd1);
      chk("t2_fc", 64'(bus.FRAME_COUNT), 64'd1);
      chk("t2_dout0", bus.DOUT, 64'hAAAA_0000_0000_0020);
      rd();
      chk("t2_dout1", bus.DOUT, 64'h0000_0000_0000_0021);
      rd();
      chk("t2_dout2", bus.DOUT, FTR);
      rd();

      // 3: 20-word frame overflows a 15-slot buffer
      wr(64'hAAAA_0000_0000_0100);
      for (int i = 1; i <= 18; i++) wr(64'(i) + 64'h100);
      wr(FTR);
      chk("t3_drop", 64'(bus.DROP_COUNT), 64'd2);
      chk("t3_fc", 64'(bus.FRAME_COUNT), 64'd0);
      chk("t3_rr", 64'(bus.READ_REQUEST), 64'd0);
      wr(64'hAAAA_0000_0000_0200);
      wr(64'h0000_0000_0000_0201);
      wr(FTR);
      chk("t3_fc_after", 64'(bus.FRAME_COUNT), 64'd1);
      chk("t3_dout", bus.DOUT, 64'hAAAA_0000_0000_0200);
      for (int i = 0; i < 3; i++) rd();

      // 4: commit and footer consume on the same edge, then underflow
      for (int f = 1; f <= 2; f++) begin
         wr(64'hAAAA_0000_0000_0300 + 64'(f));
         wr(64'h0000_0000_0000_0300 + 64'(f));
         wr(FTR);
      end
      chk("t4_fc2", 64'(bus.FRAME_COUNT), 64'd2);
      cyc(1'b1, 1'b1, 64'hAAAA_0000_0000_0303, 1'b1);
      cyc(1'b1, 1'b1, 64'h0000_0000_0000_0303, 1'b1);
      chk("t4_dout_ftr", bus.DOUT, FTR);
      cyc(1'b1, 1'b1, FTR, 1'b1);
      chk("t4_fc_same_edge", 64'(bus.FRAME_COUNT), 64'd2);
      for (int i = 0; i < 6; i++) rd();
      chk("t4_fc0", 64'(bus.FRAME_COUNT), 64'd0);
      chk("t4_uf_clear", 64'(bus.UNDERFLOW), 64'd0);
      rd();
      rd();
      chk("t4_uf", 64'(bus.UNDERFLOW), 64'd1);
      wr(64'hAAAA_0000_0000_0400);
      wr(FTR);
      chk("t4_rdptr_stable", bus.DOUT, 64'hAAAA_0000_0000_0400);
      rd();
      rd();

      // 5: stray words in IDLE, then reset mid-frame
      wr(64'h0000_0000_0000_0500);
      wr(FTR);
      chk("t5_drop", 64'(bus.DROP_COUNT), 64'd2);
      chk("t5_fc", 64'(bus.FRAME_COUNT), 64'd0);
      wr(64'hAAAA_0000_0000_0501);
      wr(64'h0000_0000_0000_0502);
      cyc(1'b0, 1'b0, 64'd0, 1'b0);
      chk("t5_rst_fc", 64'(bus.FRAME_COUNT), 64'd0);
      chk("t5_rst_drop", 64'(bus.DROP_COUNT), 64'd0);
      chk("t5_rst_rr", 64'(bus.READ_REQUEST), 64'd0);
      chk("t5_rst_uf", 64'(bus.UNDERFLOW), 64'd0);
      wr(FTR);
      chk("t5_partial_lost", 64'(bus.FRAME_COUNT), 64'd0);

      // 6: header followed by TMO idle cycles
      wr(64'hAAAA_0000_0000_0600);
      for (int i = 0; i < TMO; i++) idle();
`ifdef FRAME_TIMEOUT_EN
      chk("t6_drop", 64'(bus.DROP_COUNT), 64'd1);
`else
      chk("t6_drop", 64'(bus.DROP_COUNT), 64'd0);
`endif
      wr(64'h0000_0000_0000_0601);
      wr(FTR);
`ifdef FRAME_TIMEOUT_EN
      chk("t6_idle_state", 64'(bus.FRAME_COUNT), 64'd0);
`else
      chk("t6_idle_state", 64'(bus.FRAME_COUNT), 64'd1);
`endif
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
